roubus_cmd_rx: RTL and testbench

- Command decoder sitting directly downstream of the roubus async CDC stage, in the read-clock domain.
- Pops 32-bit words from the stage's empty/read interface, parses a header word, then executes a burst of word writes or word reads on a simple ack-handshake local bus.
- Read data is returned on a valid/ready response port that feeds the return-path CDC stage.

---
 rtl/roubus_cmd_rx.sv | 162 ++++++++++++++++
 tb/tb_roubus_cmd_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roubus_cmd_rx.sv
// roubus command decoder: pops header/data words from the CDC stage
// and runs word write/read bursts on an ack-handshake local bus.
module roubus_cmd_rx #(
  parameter int AWID = 24,
  parameter int DWID = 32,
  parameter int TOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_empty,
  input  logic [DWID-1:0] in_data,
  output logic            in_read,
  output logic [AWID-1:0] bus_addr,
  output logic [DWID-1:0] bus_wdata,
  output logic            bus_wr,
  output logic            bus_rd,
  input  logic            bus_ack,
  input  logic [DWID-1:0] bus_rdata,
  output logic            resp_valid,
  output logic [DWID-1:0] resp_data,
  input  logic            resp_ready,
  output logic            busy,
  output logic [7:0]      err_cnt
);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_WAIT,
    RD_REQ, RD_WAIT, RESP
  } state_t;

  localparam logic [7:0] TLIM = 8'(TOUT - 1);

  state_t state, state_nx;
  logic [6:0] cnt, cnt_nx;
  logic [AWID-1:0] addr, addr_nx;
  logic [DWID-1:0] wdata, wdata_nx;
  logic [DWID-1:0] rdata, rdata_nx;
  logic [7:0] tmr, tmr_nx;
  logic [7:0] err, err_nx;
  logic drop, drop_nx;
  logic guard;
  logic err_inc;
  logic last;

  // the CDC empty flag lags a pop by one clk, so the guard
  // masks the stale flag in the cycle after every pop
  assign in_read = !in_empty && !guard &&
                   (state == IDLE || state == WR_DATA);

  assign bus_addr   = addr;
  assign bus_wdata  = wdata;
  assign resp_data  = rdata;
  assign err_cnt    = err;
  assign bus_wr     = (state == WR_WAIT);
  assign bus_rd     = (state == RD_WAIT);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign last       = (cnt == 7'd1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr;
    wdata_nx = wdata;
    rdata_nx = rdata;
    tmr_nx   = tmr;
    drop_nx  = drop;
    err_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_read) begin
          unique case (in_data[31:30])
            2'b00, 2'b01: begin
              addr_nx  = in_data[AWID-1:0];
              cnt_nx   = {1'b0, in_data[29:24]} + 7'd1;
              drop_nx  = 1'b0;
              state_nx = in_data[30] ? RD_REQ : WR_DATA;
            end
            2'b10: state_nx = IDLE;
            2'b11: err_inc = 1'b1;
          endcase
        end
      end
      WR_DATA: begin
        if (in_read) begin
          if (drop) begin
            cnt_nx   = cnt - 7'd1;
            state_nx = last ? IDLE : WR_DATA;
          end else begin
            wdata_nx = in_data;
            tmr_nx   = 8'd0;
            state_nx = WR_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (bus_ack) begin
          addr_nx  = addr + AWID'(1);
          cnt_nx   = cnt - 7'd1;
          state_nx = last ? IDLE : WR_DATA;
        end else if (tmr == TLIM) begin
          // keep the stream framed: drain the rest of the burst
          err_inc  = 1'b1;
          cnt_nx   = cnt - 7'd1;
          drop_nx  = 1'b1;
          state_nx = last ? IDLE : WR_DATA;
        end else begin
          tmr_nx = tmr + 8'd1;
        end
      end
      RD_REQ: begin
        tmr_nx   = 8'd0;
        state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus_ack) begin
          rdata_nx = bus_rdata;
          state_nx = RESP;
        end else if (tmr == TLIM) begin
          err_inc  = 1'b1;
          state_nx = IDLE;
        end else begin
          tmr_nx = tmr + 8'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          addr_nx  = addr + AWID'(1);
          cnt_nx   = cnt - 7'd1;
          state_nx = last ? IDLE : RD_REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
    err_nx = (err_inc && err != 8'hFF) ? err + 8'd1 : err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      tmr   <= '0;
      err   <= '0;
      drop  <= 1'b0;
      guard <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      addr  <= addr_nx;
      wdata <= wdata_nx;
      rdata <= rdata_nx;
      tmr   <= tmr_nx;
      err   <= err_nx;
      drop  <= drop_nx;
      guard <= in_read;
    end
  end

endmodule

// File: tb/tb_roubus_cmd_rx.sv
// Directed bench for roubus_cmd_rx: CDC source with delayed empty,
// ack-delay bus target and throttled response consumer.
module tb_roubus_cmd_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_empty = 1'b1;
  logic [31:0] in_data = '0;
  logic in_read;
  logic [23:0] bus_addr;
  logic [31:0] bus_wdata;
  logic bus_wr, bus_rd;
  logic bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic resp_valid;
  logic [31:0] resp_data;
  logic resp_ready = 1'b1;
  logic busy;
  logic [7:0] err_cnt;

  roubus_cmd_rx dut (
    .clk(clk), .rst_n(rst_n),
    .in_empty(in_empty), .in_data(in_data),
    .in_read(in_read),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // CDC source: empty/data view updates one clk after a pop
  logic [31:0] q[$];
  logic pop_seen = 1'b0;
  bit gap_en = 1'b0;
  int gap = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      in_empty = 1'b1;
      gap = 0;
    end else if (pop_seen) begin
      if (q.size() > 0) void'(q.pop_front());
      if (gap_en) gap = int'($urandom_range(0, 20));
    end else if (gap > 0) begin
      gap--;
      in_empty = 1'b1;
    end else begin
      in_empty = (q.size() == 0);
      if (q.size() > 0) in_data = q[0];
    end
  end

  // bus target: ack after ack_dly request cycles
  bit ack_en = 1'b1;
  int ack_dly = 1;
  int wcnt = 0;
  logic [23:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [23:0] rd_a[$];

  always @(posedge clk) begin
    #1;
    bus_ack = 1'b0;
    if (!rst_n || !(bus_wr || bus_rd) || !ack_en) begin
      wcnt = 0;
    end else begin
      wcnt++;
      if (wcnt >= ack_dly) begin
        wcnt = 0;
        bus_ack = 1'b1;
        bus_rdata = {8'hA5, bus_addr};
        if (bus_wr) begin
          wr_a.push_back(bus_addr);
          wr_d.push_back(bus_wdata);
        end else begin
          rd_a.push_back(bus_addr);
        end
      end
    end
  end

  // response consumer: ready every third cycle when throttled
  bit rr_mode = 1'b0;
  int rr_cnt = 0;
  always @(posedge clk) begin
    #1;
    rr_cnt++;
    resp_ready = rr_mode ? (rr_cnt % 3 == 0) : 1'b1;
  end

  // monitors
  int cyc = 0;
  int last_pop = 0;
  int wr_lat = -1;
  int rd_lat = -1;
  int wr_hi = 0;
  int v_empty = 0;
  int v_b2b = 0;
  int v_rdst = 0;
  logic prev_pop = 1'b0;
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;
  logic [31:0] rsp[$];

  always @(negedge clk) begin
    cyc++;
    pop_seen = in_read;
    if (in_read && in_empty) v_empty++;
    if (in_read && prev_pop) v_b2b++;
    if (resp_valid && bus_rd) v_rdst++;
    if (bus_wr) wr_hi++;
    if (bus_wr && !prev_wr) wr_lat = cyc - last_pop;
    if (bus_rd && !prev_rd && rd_lat < 0)
      rd_lat = cyc - last_pop;
    if (resp_valid && resp_ready) rsp.push_back(resp_data);
    if (in_read) last_pop = cyc;
    prev_pop = in_read;
    prev_wr = bus_wr;
    prev_rd = bus_rd;
  end

  task automatic wait_idle(string tag, int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || busy) && n < lim);
    chk({tag, "_done"}, 32'(n < lim), 32'd1);
  endtask

  initial begin
    int b, n;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_read", 32'(in_read), 0);
    chk("rst_bus_wr", 32'(bus_wr), 0);
    chk("rst_bus_rd", 32'(bus_rd), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_cnt), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single write, ack after 3 cycles
    ack_dly = 3;
    q.push_back(32'h0000_1000);
    q.push_back(32'hDEAD_BEEF);
    n = 0;
    while (!bus_ack && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w1_ack_seen", 32'(bus_ack), 1);
    chk("w1_bus_wr", 32'(bus_wr), 1);
    chk("w1_addr", 32'(bus_addr), 32'h1000);
    chk("w1_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("w1_busy_at_ack", 32'(busy), 1);
    @(negedge clk);
    chk("w1_busy_after", 32'(busy), 0);
    chk("w1_wr_lat", 32'(wr_lat), 1);
    chk("w1_nwr", 32'(wr_a.size()), 1);

    // read burst with wrap, throttled consumer
    ack_dly = 1;
    rr_mode = 1'b1;
    rd_lat = -1;
    q.push_back(32'h43FF_FFFE);
    wait_idle("r4", 500);
    chk("r4_rd_lat", 32'(rd_lat), 2);
    chk("r4_nrd", 32'(rd_a.size()), 4);
    chk("r4_nrsp", 32'(rsp.size()), 4);
    for (int i = 0; i < 4; i++) begin
      logic [23:0] ea;
      ea = 24'hFF_FFFE + 24'(i);
      if (i < rd_a.size())
        chk($sformatf("r4_addr%0d", i), 32'(rd_a[i]), 32'(ea));
      if (i < rsp.size())
        chk($sformatf("r4_rsp%0d", i), rsp[i], {8'hA5, ea});
    end
    chk("r4_rd_in_stall", 32'(v_rdst), 0);
    rr_mode = 1'b0;

    // write burst with random empty gaps
    gap_en = 1'b1;
    ack_dly = 2;
    b = wr_a.size();
    q.push_back(32'h0400_0200);
    for (int i = 0; i < 5; i++) q.push_back(32'h1111_0000 + i);
    wait_idle("gap", 2000);
    chk("gap_nwr", 32'(wr_a.size() - b), 5);
    for (int i = 0; i < 5; i++) begin
      if (b + i < wr_a.size()) begin
        chk($sformatf("gap_addr%0d", i),
            32'(wr_a[b+i]), 32'h200 + i);
        chk($sformatf("gap_data%0d", i),
            wr_d[b+i], 32'h1111_0000 + i);
      end
    end
    gap_en = 1'b0;
    repeat (30) @(negedge clk);
    chk("pop_when_empty", 32'(v_empty), 0);
    chk("pop_b2b", 32'(v_b2b), 0);

    // reserved + nop headers, then a normal write
    ack_dly = 1;
    b = wr_a.size();
    q.push_back(32'hC000_0000);
    q.push_back(32'h8000_0000);
    q.push_back(32'h0000_0300);
    q.push_back(32'h1234_5678);
    wait_idle("rsv", 200);
    chk("rsv_err", 32'(err_cnt), 1);
    chk("rsv_nwr", 32'(wr_a.size() - b), 1);
    if (b < wr_a.size()) begin
      chk("rsv_addr", 32'(wr_a[b]), 32'h300);
      chk("rsv_data", wr_d[b], 32'h1234_5678);
    end

    // write timeout, second word drained
    ack_en = 1'b0;
    b = wr_a.size();
    wr_hi = 0;
    q.push_back(32'h0100_0400);
    q.push_back(32'hAAAA_0001);
    q.push_back(32'hAAAA_0002);
    wait_idle("tmo", 1000);
    chk("tmo_wr_cycles", 32'(wr_hi), 255);
    chk("tmo_err", 32'(err_cnt), 2);
    chk("tmo_nwr", 32'(wr_a.size() - b), 0);
    chk("tmo_q_drained", 32'(q.size()), 0);
    repeat (3) @(negedge clk);
    chk("tmo_busy", 32'(busy), 0);

    // async reset during RD_WAIT
    q.push_back(32'h4000_0500);
    n = 0;
    while (!bus_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_rd_seen", 32'(bus_rd), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_bus_rd", 32'(bus_rd), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_in_read", 32'(in_read), 0);
    chk("mrst_addr", 32'(bus_addr), 0);
    chk("mrst_wdata", bus_wdata, 0);
    chk("mrst_resp_data", resp_data, 0);
    chk("mrst_err", 32'(err_cnt), 0);
    q.delete();
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b = wr_a.size();
    q.push_back(32'h0000_0600);
    q.push_back(32'hCAFE_F00D);
    wait_idle("post", 200);
    chk("post_nwr", 32'(wr_a.size() - b), 1);
    if (b < wr_a.size()) begin
      chk("post_addr", 32'(wr_a[b]), 32'h600);
      chk("post_data", wr_d[b], 32'hCAFE_F00D);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
